// File: rtl/alu_sequencer_pkg.sv
// alu_seq_pkg: definitions shared by the ALU sequencer, its op interface and
// the code that drives it.
//   - op_kind codes carried on the op channel
//   - FSM state encoding
//   - alu select/opcode pair that performs an add
package alu_seq_pkg;

  // op_kind encodings
  localparam logic [1:0] OPK_ALU      = 2'b00;
  localparam logic [1:0] OPK_LOAD_IMM = 2'b01;
  localparam logic [1:0] OPK_MOVE     = 2'b10;
  localparam logic [1:0] OPK_NOP      = 2'b11;

  // Sequencer states; 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // alu control pair for an add
  localparam logic       ALU_ADD_SEL = 1'b0;
  localparam logic [2:0] ALU_ADD_OPC = 3'b000;

  // True for kinds that read the regfile in an EXEC cycle before write-back
  function automatic logic needs_exec(input logic [1:0] kind);
    return (kind == OPK_ALU) || (kind == OPK_MOVE);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: valid/ready operation channel into the ALU sequencer.
//   op_valid  producer offers an operation
//   op_ready  sequencer can accept it (handshake = op_valid & op_ready)
//   op_kind   00=ALU, 01=LOAD_IMM, 10=MOVE, 11=NOP
//   op_select / op_opcode  alu controls for ALU ops
//   op_dst / op_src1 / op_src2  register selects
//   op_imm    immediate for LOAD_IMM
// modport master: operation producer; modport slave: the sequencer.
interface alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) ();

  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_kind;
  logic              op_select;
  logic [2:0]        op_opcode;
  logic [SEL_W-1:0]  op_dst;
  logic [SEL_W-1:0]  op_src1;
  logic [SEL_W-1:0]  op_src2;
  logic [DATA_W-1:0] op_imm;

  modport master (
    output op_valid, op_kind, op_select, op_opcode,
    output op_dst, op_src1, op_src2, op_imm,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_kind, op_select, op_opcode,
    input  op_dst, op_src1, op_src2, op_imm,
    output op_ready
  );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences register-level operations onto an external
// regfile and alu. One operation per handshake; IDLE -> (EXEC) -> WB -> IDLE.
//   clk, rst        clock; asynchronous active-high reset
//   op_if (slave)   operation channel
//   rf_in1_*        regfile write port 1 (strobed only in WB)
//   rf_in2_we       regfile write port 2 enable, tied low
//   rf_out1/2_sel   regfile read selects, loaded on entry to EXEC
//   rf_out1/2_data  regfile read data
//   alu_select/opcode  alu controls, non-zero only in EXEC of an ALU op
//   alu_result/cf/of   alu outputs
//   done            high for the WB cycle
//   flag_cf/flag_of carry/overflow of ALU ops
//   flag_clr        flag clear, honoured only with sticky flags
// Optional build macro ALU_SEQ_STICKY_FLAGS_EN: flags accumulate (OR) across
// ALU ops until flag_clr; otherwise each ALU op overwrites them.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    op_if,
  output logic              rf_in1_we,
  output logic [SEL_W-1:0]  rf_in1_sel,
  output logic [DATA_W-1:0] rf_in1_data,
  output logic              rf_in2_we,
  output logic [SEL_W-1:0]  rf_out1_sel,
  output logic [SEL_W-1:0]  rf_out2_sel,
  input  logic [DATA_W-1:0] rf_out1_data,
  input  logic [DATA_W-1:0] rf_out2_data,
  output logic              alu_select,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cf,
  input  logic              alu_of,
  output logic              done,
  output logic              flag_cf,
  output logic              flag_of,
  input  logic              flag_clr
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              alu_exec_s;
  logic [1:0]        cap_kind_r;
  logic [SEL_W-1:0]  cap_dst_r;
  logic              op_ready_r;
  logic              rf_in1_we_r;
  logic              done_r;
  logic [SEL_W-1:0]  rf_in1_sel_r;
  logic [DATA_W-1:0] rf_in1_data_r;
  logic [SEL_W-1:0]  rf_out1_sel_r;
  logic [SEL_W-1:0]  rf_out2_sel_r;
  logic              alu_select_r;
  logic [2:0]        alu_opcode_r;
  logic              flag_cf_r;
  logic              flag_of_r;
  logic [SEL_W-1:0]  wb_sel_s;
  logic [DATA_W-1:0] wb_data_s;

  // The state qualifier makes acceptance depend on the FSM itself, not only on
  // the registered ready copy.
  assign accept_s   = op_if.op_valid & op_ready_r & (state_r == ST_IDLE);
  assign alu_exec_s = (state_r == ST_EXEC) && (cap_kind_r == OPK_ALU);

  // Next-state decode
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (needs_exec(op_if.op_kind)) begin
            state_nxt_s = ST_EXEC;
          end else if (op_if.op_kind == OPK_LOAD_IMM) begin
            state_nxt_s = ST_WB;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_WB;
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Write-back destination and data for the WB cycle being entered
  always_comb begin
    wb_sel_s  = cap_dst_r;
    wb_data_s = rf_in1_data_r;
    if (state_r == ST_EXEC) begin
      wb_sel_s = cap_dst_r;
      if (cap_kind_r == OPK_ALU) begin
        wb_data_s = alu_result;
      end else begin
        wb_data_s = rf_out1_data;
      end
    end else begin
      // Only a LOAD_IMM enters WB directly from IDLE
      wb_sel_s  = op_if.op_dst;
      wb_data_s = op_if.op_imm;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the op fields still needed after acceptance; the remaining fields
  // are captured directly into the output registers below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_kind_r <= 2'b00;
      cap_dst_r  <= '0;
    end else if (accept_s) begin
      cap_kind_r <= op_if.op_kind;
      cap_dst_r  <= op_if.op_dst;
    end
  end

  // Registered outputs, decoded from the state being entered so that each
  // one is aligned with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ready_r    <= 1'b1;
      rf_in1_we_r   <= 1'b0;
      done_r        <= 1'b0;
      rf_in1_sel_r  <= '0;
      rf_in1_data_r <= '0;
      rf_out1_sel_r <= '0;
      rf_out2_sel_r <= '0;
      alu_select_r  <= 1'b0;
      alu_opcode_r  <= 3'b000;
    end else begin
      op_ready_r  <= (state_nxt_s == ST_IDLE);
      rf_in1_we_r <= (state_nxt_s == ST_WB);
      done_r      <= (state_nxt_s == ST_WB);
      if (state_nxt_s == ST_WB) begin
        rf_in1_sel_r  <= wb_sel_s;
        rf_in1_data_r <= wb_data_s;
      end
      // EXEC is entered only from IDLE, so the op fields are on the channel
      if (state_nxt_s == ST_EXEC) begin
        rf_out1_sel_r <= op_if.op_src1;
        rf_out2_sel_r <= op_if.op_src2;
      end
      if ((state_nxt_s == ST_EXEC) && (op_if.op_kind == OPK_ALU)) begin
        alu_select_r <= op_if.op_select;
        alu_opcode_r <= op_if.op_opcode;
      end else begin
        alu_select_r <= 1'b0;
        alu_opcode_r <= 3'b000;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  // Sticky flags: accumulate over ALU ops; a clear wins over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_cf_r <= 1'b0;
      flag_of_r <= 1'b0;
    end else if (flag_clr) begin
      flag_cf_r <= 1'b0;
      flag_of_r <= 1'b0;
    end else if (alu_exec_s) begin
      flag_cf_r <= flag_cf_r | alu_cf;
      flag_of_r <= flag_of_r | alu_of;
    end
  end
`else
  logic unused_flag_clr_s;
  assign unused_flag_clr_s = flag_clr;

  // Flags reflect the most recent ALU op only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_cf_r <= 1'b0;
      flag_of_r <= 1'b0;
    end else if (alu_exec_s) begin
      flag_cf_r <= alu_cf;
      flag_of_r <= alu_of;
    end
  end
`endif

  assign op_if.op_ready = op_ready_r;
  assign rf_in1_we      = rf_in1_we_r;
  assign rf_in1_sel     = rf_in1_sel_r;
  assign rf_in1_data    = rf_in1_data_r;
  assign rf_in2_we      = 1'b0;
  assign rf_out1_sel    = rf_out1_sel_r;
  assign rf_out2_sel    = rf_out2_sel_r;
  assign alu_select     = alu_select_r;
  assign alu_opcode     = alu_opcode_r;
  assign done           = done_r;
  assign flag_cf        = flag_cf_r;
  assign flag_of        = flag_of_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a behavioural regfile and
// alu, and compares every commit, handshake cycle, flag and final register
// contents with a reference model that executes each operation directly on
// an array of register values.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [1:0]  kind;
    logic        sel;
    logic [2:0]  opc;
    logic [3:0]  dst;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] imm;
  } op_t;

  logic        clk;
  logic        rst;
  logic        flag_clr;
  logic        rf_in1_we;
  logic [3:0]  rf_in1_sel;
  logic [15:0] rf_in1_data;
  logic        rf_in2_we;
  logic [3:0]  rf_out1_sel;
  logic [3:0]  rf_out2_sel;
  logic [15:0] rf_out1_data;
  logic [15:0] rf_out2_data;
  logic        alu_select;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_cf;
  logic        alu_of;
  logic        done;
  logic        flag_cf;
  logic        flag_of;

  logic        rf_clear;
  logic [15:0] rf [16];
  logic [15:0] g [16];
  logic        exp_cf;
  logic        exp_of;
  int          checks;
  int          errors;

  alu_sequencer_if #(.DATA_W(16), .SEL_W(4)) op_if ();

  alu_sequencer #(.DATA_W(16), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .op_if(op_if),
    .rf_in1_we(rf_in1_we), .rf_in1_sel(rf_in1_sel), .rf_in1_data(rf_in1_data),
    .rf_in2_we(rf_in2_we), .rf_out1_sel(rf_out1_sel), .rf_out2_sel(rf_out2_sel),
    .rf_out1_data(rf_out1_data), .rf_out2_data(rf_out2_data),
    .alu_select(alu_select), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .alu_cf(alu_cf), .alu_of(alu_of), .done(done),
    .flag_cf(flag_cf), .flag_of(flag_of), .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu: returns {of, cf, result}
  function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic sel, input logic [2:0] opc);
    logic [16:0] s;
    logic [15:0] r;
    logic        cf;
    logic        of;
    cf = 1'b0;
    of = 1'b0;
    r  = 16'd0;
    if (!sel) begin
      case (opc)
        3'd0: begin
          s  = {1'b0, a} + {1'b0, b};
          r  = s[15:0];
          cf = s[16];
          of = (a[15] == b[15]) && (r[15] != a[15]);
        end
        3'd1: begin
          r  = a - b;
          cf = (a < b);
          of = (a[15] != b[15]) && (r[15] != a[15]);
        end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = a;
        3'd6: r = b;
        default: r = ~a;
      endcase
    end else begin
      r  = {a[14:0], 1'b0};
      cf = a[15];
    end
    return {of, cf, r};
  endfunction

  assign {alu_of, alu_cf, alu_result} = alu_fn(rf_out1_data, rf_out2_data, alu_select, alu_opcode);

  // Behavioural regfile: combinational reads, write port 1 commits on posedge
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
    end else if (rf_in1_we) begin
      rf[rf_in1_sel] <= rf_in1_data;
    end
  end
  assign rf_out1_data = rf[rf_out1_sel];
  assign rf_out2_data = rf[rf_out2_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic [1:0] kind, input logic sel, input logic [2:0] opc,
                             input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [15:0] imm);
    op_t o;
    o.kind = kind; o.sel = sel; o.opc = opc;
    o.dst = dst; o.s1 = s1; o.s2 = s2; o.imm = imm;
    return o;
  endfunction

  // Reference model: execute one operation on the register array and flags
  function automatic logic [15:0] golden_step(input op_t o);
    logic [17:0] r;
    logic [15:0] w;
    w = 16'd0;
    case (o.kind)
      OPK_ALU: begin
        r = alu_fn(g[o.s1], g[o.s2], o.sel, o.opc);
        w = r[15:0];
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        exp_cf = exp_cf | r[16];
        exp_of = exp_of | r[17];
`else
        exp_cf = r[16];
        exp_of = r[17];
`endif
        g[o.dst] = w;
      end
      OPK_LOAD_IMM: begin w = o.imm;     g[o.dst] = w; end
      OPK_MOVE:     begin w = g[o.s1];   g[o.dst] = w; end
      default:      w = 16'd0;
    endcase
    return w;
  endfunction

  task automatic present(input op_t o);
    op_if.op_kind   = o.kind;
    op_if.op_select = o.sel;
    op_if.op_opcode = o.opc;
    op_if.op_dst    = o.dst;
    op_if.op_src1   = o.s1;
    op_if.op_src2   = o.s2;
    op_if.op_imm    = o.imm;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 16; i++) chk($sformatf("rf_r%0d", i), 32'(rf[i]), 32'(g[i]));
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_cf"}, 32'(flag_cf), 32'(exp_cf));
    chk({tag, "_of"}, 32'(flag_of), 32'(exp_of));
  endtask

  // Issue one op and check every cycle up to the return to IDLE
  task automatic run_op(input op_t o);
    logic [15:0] wdata;
    int          lat;
    lat   = (o.kind == OPK_LOAD_IMM) ? 1 : ((o.kind == OPK_ALU || o.kind == OPK_MOVE) ? 2 : 0);
    wdata = golden_step(o);
    @(negedge clk);
    chk("ready_idle", 32'(op_if.op_ready), 32'd1);
    present(o);
    op_if.op_valid = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      op_if.op_valid = 1'b0;
      chk("done", 32'(done), 32'(c == lat));
      chk("we", 32'(rf_in1_we), 32'(c == lat));
      chk("ready", 32'(op_if.op_ready), 32'(c > lat));
      chk("in2_we", 32'(rf_in2_we), 32'd0);
      if (c == lat) begin
        chk("wb_sel", 32'(rf_in1_sel), 32'(o.dst));
        chk("wb_data", 32'(rf_in1_data), 32'(wdata));
      end
    end
    check_flags("op_flag");
  endtask

  initial begin
    op_t         o;
    op_t         bb [3];
    int          idx;
    int          ndone;
    logic        acc1;
    logic        acc2;
    logic        acc_now;

    checks = 0;
    errors = 0;
    exp_cf = 1'b0;
    exp_of = 1'b0;
    for (int i = 0; i < 16; i++) g[i] = 16'd0;
    rst = 1'b1;
    rf_clear = 1'b1;
    flag_clr = 1'b0;
    op_if.op_valid = 1'b0;
    present(mk(2'b00, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 16'd0));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(op_if.op_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(rf_in1_we), 32'd0);
    chk("rst_out1_sel", 32'(rf_out1_sel), 32'd0);
    chk("rst_out2_sel", 32'(rf_out2_sel), 32'd0);
    chk("rst_in1_sel", 32'(rf_in1_sel), 32'd0);
    chk("rst_alu_ctl", 32'({alu_select, alu_opcode}), 32'd0);
    check_flags("rst_flag");
    rst = 1'b0;
    rf_clear = 1'b0;

    // Immediate loads and an add
    run_op(mk(OPK_LOAD_IMM, 1'b0, 3'd0, 4'd1, 4'd0, 4'd0, 16'd15));
    run_op(mk(OPK_LOAD_IMM, 1'b0, 3'd0, 4'd2, 4'd0, 4'd0, 16'd30));
    chk("r1_eq_15", 32'(rf[1]), 32'd15);
    chk("r2_eq_30", 32'(rf[2]), 32'd30);
    run_op(mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd3, 4'd1, 4'd2, 16'd0));
    chk("r3_eq_45", 32'(rf[3]), 32'd45);
    chk("add_no_cf", 32'(flag_cf), 32'd0);

    // Carry-out add, then a MOVE that must not disturb flags
    run_op(mk(OPK_LOAD_IMM, 1'b0, 3'd0, 4'd4, 4'd0, 4'd0, 16'hFFFF));
    run_op(mk(OPK_LOAD_IMM, 1'b0, 3'd0, 4'd5, 4'd0, 4'd0, 16'd1));
    run_op(mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd6, 4'd4, 4'd5, 16'd0));
    chk("r6_wrap", 32'(rf[6]), 32'd0);
    chk("carry_set", 32'(flag_cf), 32'd1);
    run_op(mk(OPK_MOVE, 1'b0, 3'd0, 4'd7, 4'd6, 4'd0, 16'd0));
    chk("move_keeps_cf", 32'(flag_cf), 32'd1);

    // Reserved kind: no write, no done
    run_op(mk(OPK_NOP, 1'b0, 3'd0, 4'd9, 4'd1, 4'd2, 16'h1234));
    check_rf();

    // Reset during EXEC abandons the op; ready and flags clear immediately
    @(negedge clk);
    present(mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd8, 4'd1, 4'd2, 16'd0));
    op_if.op_valid = 1'b1;
    @(negedge clk);
    op_if.op_valid = 1'b0;
    chk("exec_not_ready", 32'(op_if.op_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    exp_cf = 1'b0;
    exp_of = 1'b0;
    chk("arst_ready", 32'(op_if.op_ready), 32'd1);
    chk("arst_we", 32'(rf_in1_we), 32'd0);
    check_flags("arst_flag");
    @(negedge clk);
    chk("arst_hold_we", 32'(rf_in1_we), 32'd0);
    chk("arst_hold_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_after_we", 32'(rf_in1_we), 32'd0);
    chk("r8_unchanged", 32'(rf[8]), 32'(g[8]));

    // op_valid held high with three queued ops (includes a read-after-write)
    bb[0] = mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd9, 4'd1, 4'd2, 16'd0);
    bb[1] = mk(OPK_MOVE, 1'b0, 3'd0, 4'd10, 4'd9, 4'd0, 16'd0);
    bb[2] = mk(OPK_ALU, 1'b0, 3'd1, 4'd11, 4'd2, 4'd1, 16'd0);
    idx = 0;
    ndone = 0;
    acc1 = 1'b0;
    acc2 = 1'b0;
    @(negedge clk);
    present(bb[0]);
    op_if.op_valid = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (acc1) begin
        idx++;
        if (idx < 3) present(bb[idx]);
        else op_if.op_valid = 1'b0;
      end
      chk("bb_ready", 32'(op_if.op_ready), 32'(!(acc1 || acc2)));
      chk("bb_done", 32'(done), 32'(acc2));
      chk("bb_we", 32'(rf_in1_we), 32'(acc2));
      if (done) ndone++;
      acc_now = op_if.op_valid && op_if.op_ready;
      if (acc_now && idx < 3) void'(golden_step(bb[idx]));
      acc2 = acc1;
      acc1 = acc_now;
      @(negedge clk);
    end
    op_if.op_valid = 1'b0;
    chk("bb_done_count", 32'(ndone), 32'd3);
    chk("r10_raw", 32'(rf[10]), 32'd45);
    check_flags("bb_flag");
    check_rf();

    // Carry add, non-carry add, then a flag_clr pulse
    run_op(mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd12, 4'd4, 4'd5, 16'd0));
    run_op(mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd13, 4'd1, 4'd2, 16'd0));
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    chk("sticky_cf", 32'(flag_cf), 32'd1);
`else
    chk("overwrite_cf", 32'(flag_cf), 32'd0);
`endif
    run_op(mk(OPK_ALU, ALU_ADD_SEL, ALU_ADD_OPC, 4'd12, 4'd4, 4'd5, 16'd0));
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    exp_cf = 1'b0;
    exp_of = 1'b0;
`endif
    check_flags("clr_flag");

    // Randomized operations against the reference model
    for (int k = 0; k < 60; k++) begin
      o = mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             16'($urandom_range(0, 65535)));
      run_op(o);
      if (k % 10 == 9) check_rf();
    end
    check_rf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
